// File: rtl/fp_mult_share_arb_pkg.sv
// fp_arb_pkg: shared definitions for the FP32 multiplier share arbiter.
//   FP32_W   operand / product width
//   MAX_REQ  widest requester vector the pick helper handles
//   IDX_W    width of a requester index (owner, pointer, tag)
//   state_t  arbiter FSM state {ARB, BURST}
//   rr_pick  round-robin search: first valid at or after ptr, modulo num
package fp_arb_pkg;

  localparam int FP32_W  = 32;
  localparam int MAX_REQ = 8;
  localparam int IDX_W   = 3;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } pick_t;

  // Scans num entries starting at ptr (ptr < num). The scan runs from the
  // farthest offset down so the nearest valid entry is the one that sticks.
  function automatic pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                    input logic [IDX_W-1:0]   ptr,
                                    input logic [IDX_W:0]     num);
    pick_t            res;
    logic [IDX_W:0]   j;
    res = '0;
    for (int off = MAX_REQ - 1; off >= 0; off--) begin
      if ((IDX_W+1)'(off) < num) begin
        j = {1'b0, ptr} + (IDX_W+1)'(off);
        if (j >= num) j = j - num;
        if (valid[j[IDX_W-1:0]]) begin
          res.found = 1'b1;
          res.idx   = j[IDX_W-1:0];
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fp_mult_share_arb_tag_pipe.sv
// fp_mult_tag_pipe: DEPTH-stage valid/owner shift register that runs in
// step with the multiplier so each product leaves with its owner.
//   clk, reset    clock, synchronous active-high clear of all valids
//   i_valid/i_tag input-stage valid and owner index
//   o_valid/o_tag last-stage valid and owner index
//   o_any_valid   any stage holds a live product
module fp_mult_tag_pipe
  import fp_arb_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [IDX_W-1:0] i_tag,
  output logic             o_valid,
  output logic [IDX_W-1:0] o_tag,
  output logic             o_any_valid
);

  logic [DEPTH-1:0] r_valid;
  logic [IDX_W-1:0] r_tag [DEPTH];

  always_ff @(posedge clk) begin
    r_tag[0] <= i_tag;
    for (int s = 1; s < DEPTH; s++) r_tag[s] <= r_tag[s-1];
    if (reset) begin
      r_valid <= '0;
    end else begin
      r_valid[0] <= i_valid;
      for (int s = 1; s < DEPTH; s++) r_valid[s] <= r_valid[s-1];
    end
  end

  assign o_valid     = r_valid[DEPTH-1];
  assign o_tag       = r_tag[DEPTH-1];
  assign o_any_valid = |r_valid;

endmodule

// File: rtl/multiply_fp_clk.sv
// multiply_fp_clk: behavioural FP32 multiplier standing in for the DSP
// primitive of the same name. Product is registered LAT times.
//   a, b  FP32 operands
//   clk   clock
//   out   FP32 product, LAT cycles after a/b
// Normal operands are rounded to nearest-even; denormal inputs and
// underflowing results flush to signed zero, overflow gives infinity.
module multiply_fp_clk #(
  parameter int LAT = 1
) (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        clk,
  output logic [31:0] out
);

  logic        w_sign, w_a_zero, w_b_zero, w_a_inf, w_b_inf, w_a_nan, w_b_nan;
  logic [47:0] w_p;
  logic [23:0] w_m;
  logic        w_r, w_s;
  logic [24:0] w_mr;
  logic [9:0]  w_e;
  logic [22:0] w_frac;
  logic [31:0] w_prod;
  logic [31:0] r_pipe [LAT];

  always_comb begin
    w_sign   = a[31] ^ b[31];
    w_a_zero = (a[30:23] == 8'h00);
    w_b_zero = (b[30:23] == 8'h00);
    w_a_inf  = (a[30:23] == 8'hFF) && (a[22:0] == 23'h0);
    w_b_inf  = (b[30:23] == 8'hFF) && (b[22:0] == 23'h0);
    w_a_nan  = (a[30:23] == 8'hFF) && (a[22:0] != 23'h0);
    w_b_nan  = (b[30:23] == 8'hFF) && (b[22:0] != 23'h0);
    w_p      = 48'({1'b1, a[22:0]}) * 48'({1'b1, b[22:0]});
    // Product of two [1,2) mantissas lies in [1,4): normalise on bit 47.
    if (w_p[47]) begin
      w_m = w_p[47:24];
      w_r = w_p[23];
      w_s = |w_p[22:0];
    end else begin
      w_m = w_p[46:23];
      w_r = w_p[22];
      w_s = |w_p[21:0];
    end
    w_mr   = {1'b0, w_m} + 25'(w_r & (w_s | w_m[0]));
    w_frac = w_mr[24] ? w_mr[23:1] : w_mr[22:0];
    // Biased sum, still carrying one extra bias of 127.
    w_e    = 10'(a[30:23]) + 10'(b[30:23]) + 10'(w_p[47]) + 10'(w_mr[24]);
    if (w_a_nan || w_b_nan || (w_a_inf && w_b_zero) || (w_b_inf && w_a_zero))
      w_prod = 32'h7FC0_0000;
    else if (w_a_inf || w_b_inf)
      w_prod = {w_sign, 8'hFF, 23'h0};
    else if (w_a_zero || w_b_zero)
      w_prod = {w_sign, 31'h0};
    else if (w_e >= 10'd382)
      w_prod = {w_sign, 8'hFF, 23'h0};
    else if (w_e <= 10'd127)
      w_prod = {w_sign, 31'h0};
    else
      w_prod = {w_sign, 8'(w_e - 10'd127), w_frac};
  end

  always_ff @(posedge clk) begin
    r_pipe[0] <= w_prod;
    for (int s = 1; s < LAT; s++) r_pipe[s] <= r_pipe[s-1];
  end

  assign out = r_pipe[LAT-1];

endmodule

// File: rtl/fp_mult_share_arb.sv
// fp_mult_share_arb: round-robin arbiter sharing one pipelined FP32
// multiplier among NUM_REQ requesters, with bounded bursts and tagged
// result routing.
//   clk, reset             clock, synchronous active-high reset
//   req_valid/req_a/req_b  per-requester operand pair offers
//   req_ready              one-hot or zero grant (combinational)
//   rsp_valid              one-hot pulse marking whose product is on rsp_data
//   rsp_data               registered FP32 product, holds between pulses
//   busy                   registered: input stage or tag pipe occupied
// Handshake: an operand pair moves when req_valid[i] & req_ready[i] is high
// at a rising edge; requesters hold req_a/req_b while valid and not ready.
// Responses have no backpressure and return in acceptance order.
module fp_mult_share_arb
  import fp_arb_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int MULT_LAT  = 1,
  parameter int BURST_MAX = 4
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*FP32_W-1:0] req_a,
  input  logic [NUM_REQ*FP32_W-1:0] req_b,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [FP32_W-1:0]         rsp_data,
  output logic                      busy
);

  localparam int CNT_W = $clog2(BURST_MAX + 1);

  state_t             r_state;
  logic [IDX_W-1:0]   r_owner, r_rr_ptr, r_tag_q;
  logic [CNT_W-1:0]   r_burst_cnt;
  logic               r_v_q, r_busy;
  logic [FP32_W-1:0]  r_a_q, r_b_q, r_rsp_data;
  logic [NUM_REQ-1:0] r_rsp_valid;

  logic [MAX_REQ-1:0] w_valid_pad;
  logic [IDX_W-1:0]   w_owner_inc, w_grant_idx, w_tag;
  pick_t              w_pick_arb, w_pick_rot;
  logic               w_grant_ok, w_hold, w_rearb, w_tag_v, w_tag_any;
  logic [FP32_W-1:0]  w_a_sel, w_b_sel, w_mult_out;

  assign w_owner_inc = (r_owner == IDX_W'(NUM_REQ - 1)) ? '0 : r_owner + IDX_W'(1);

  // Grant selection. Leaving a burst (owner dropped or hit BURST_MAX) scans
  // from owner+1 in the same cycle; that scan wraps back to the owner, so a
  // lone owner at the limit is simply re-granted with a fresh count.
  always_comb begin
    w_valid_pad                = '0;
    w_valid_pad[NUM_REQ-1:0]   = req_valid;
    w_pick_arb  = rr_pick(w_valid_pad, r_rr_ptr, (IDX_W+1)'(NUM_REQ));
    w_pick_rot  = rr_pick(w_valid_pad, w_owner_inc, (IDX_W+1)'(NUM_REQ));
    w_hold      = 1'b0;
    w_rearb     = 1'b0;
    w_grant_ok  = 1'b0;
    w_grant_idx = '0;
    if (r_state == ARB) begin
      w_grant_ok  = w_pick_arb.found;
      w_grant_idx = w_pick_arb.idx;
    end else if (w_valid_pad[r_owner] && (r_burst_cnt < CNT_W'(BURST_MAX))) begin
      w_hold      = 1'b1;
      w_grant_ok  = 1'b1;
      w_grant_idx = r_owner;
    end else begin
      w_rearb     = 1'b1;
      w_grant_ok  = w_pick_rot.found;
      w_grant_idx = w_pick_rot.idx;
    end
    if (reset) w_grant_ok = 1'b0;
  end

  // Grants only ever go to a valid requester, so a grant is a transfer.
  always_comb begin
    req_ready = '0;
    w_a_sel   = '0;
    w_b_sel   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      req_ready[i] = w_grant_ok && (w_grant_idx == IDX_W'(i));
      if (w_grant_idx == IDX_W'(i)) begin
        w_a_sel = req_a[i*FP32_W +: FP32_W];
        w_b_sel = req_b[i*FP32_W +: FP32_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ARB;
      r_owner     <= '0;
      r_burst_cnt <= '0;
      r_rr_ptr    <= '0;
    end else begin
      if (w_rearb) r_rr_ptr <= w_owner_inc;
      if (w_grant_ok) begin
        r_state     <= BURST;
        r_owner     <= w_grant_idx;
        r_burst_cnt <= w_hold ? r_burst_cnt + CNT_W'(1) : CNT_W'(1);
      end else begin
        r_state     <= ARB;
      end
    end
  end

  // Input register stage feeding the multiplier.
  always_ff @(posedge clk) begin
    if (reset) r_v_q <= 1'b0;
    else       r_v_q <= w_grant_ok;
    if (w_grant_ok) begin
      r_a_q   <= w_a_sel;
      r_b_q   <= w_b_sel;
      r_tag_q <= w_grant_idx;
    end
  end

  multiply_fp_clk #(.LAT(MULT_LAT)) u_mult (
    .a   (r_a_q),
    .b   (r_b_q),
    .clk (clk),
    .out (w_mult_out)
  );

  fp_mult_tag_pipe #(.DEPTH(MULT_LAT)) u_tag_pipe (
    .clk         (clk),
    .reset       (reset),
    .i_valid     (r_v_q),
    .i_tag       (r_tag_q),
    .o_valid     (w_tag_v),
    .o_tag       (w_tag),
    .o_any_valid (w_tag_any)
  );

  // Response stage: decode the owner into a one-hot pulse, latch the product.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= '0;
      r_rsp_data  <= '0;
      r_busy      <= 1'b0;
    end else begin
      r_busy <= r_v_q | w_tag_any;
      for (int i = 0; i < NUM_REQ; i++)
        r_rsp_valid[i] <= w_tag_v && (w_tag == IDX_W'(i));
      if (w_tag_v) r_rsp_data <= w_mult_out;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign busy      = r_busy;

endmodule

// File: tb/tb_fp_mult_share_arb.sv
module tb_fp_mult_share_arb;

  localparam int N = 4;
  localparam logic [31:0] ONE = 32'h3F80_0000;

  // ---------------- clock / reset ----------------
  logic clk, reset;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // main DUT (BURST_MAX = 4)
  logic [N-1:0]    req_valid, req_ready, rsp_valid;
  logic [N*32-1:0] req_a, req_b;
  logic [31:0]     rsp_data;
  logic            busy;
  // second DUT (BURST_MAX = 1) for the fairness scenario
  logic [N-1:0]    b1_valid, b1_ready, b1_rsp_valid;
  logic [N*32-1:0] b1_a, b1_b;
  logic [31:0]     b1_rsp_data;
  logic            b1_busy;

  fp_mult_share_arb #(.NUM_REQ(N), .MULT_LAT(1), .BURST_MAX(4)) u_dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .busy(busy));

  fp_mult_share_arb #(.NUM_REQ(N), .MULT_LAT(1), .BURST_MAX(1)) u_dut_b1 (
    .clk(clk), .reset(reset), .req_valid(b1_valid), .req_a(b1_a), .req_b(b1_b),
    .req_ready(b1_ready), .rsp_valid(b1_rsp_valid), .rsp_data(b1_rsp_data), .busy(b1_busy));

  int n_cmp, n_fail;
  logic [35:0] exp_q[$];   // {one-hot rsp_valid, product}
  logic [35:0] mon_exp;
  logic [31:0] op_a[N], op_b[N];
  int sent[N], exp_cnt[N];

  // With A = 1.0 the exact product is B: 2^(1+i) * (1 + n*2^-23).
  function automatic logic [31:0] bval(input int i, input int n);
    return {1'b0, 8'(128 + i), 23'(n)};
  endfunction

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin
    if (rsp_valid !== 4'b0000) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL rsp_unexpected: got valid=%b data=%h, required no response", rsp_valid, rsp_data);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({rsp_valid, rsp_data} !== mon_exp) begin
          n_fail++;
          $display("FAIL rsp_order: got valid=%b data=%h, required valid=%b data=%h",
                   rsp_valid, rsp_data, mon_exp[35:32], mon_exp[31:0]);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic init_stream();
    for (int i = 0; i < N; i++) begin
      sent[i] = 0; exp_cnt[i] = 0; op_a[i] = ONE; op_b[i] = bval(i, 0);
    end
  endtask

  // One cycle: present offers, sample the grant, advance past the edge.
  task automatic run_cycle(input logic [3:0] valid, output logic [3:0] got_ready);
    req_valid = valid;
    for (int i = 0; i < N; i++) begin
      req_a[i*32 +: 32] = op_a[i];
      req_b[i*32 +: 32] = op_b[i];
    end
    #1;
    got_ready = req_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (valid[i] && got_ready[i]) begin
        sent[i]++;
        op_a[i] = ONE;
        op_b[i] = bval(i, sent[i]);
      end
    end
  endtask

  task automatic idle(input int n);
    req_valid = '0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_reset();
    reset = 1'b1; req_valid = '0; b1_valid = '0;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1; req_valid = 4'hF; b1_valid = 4'hF;
    req_a = '0; req_b = '0; b1_a = '0; b1_b = '0;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready: got %b required 0000", req_ready); end
    n_cmp++; if (b1_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_b1: got %b required 0000", b1_ready); end
    @(posedge clk); #1; @(posedge clk); #1;
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL reset_rsp_valid: got %b required 0000", rsp_valid); end
    n_cmp++; if (rsp_data !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_data: got %h required 00000000", rsp_data); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", busy); end
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL reset_ready_held: got %b required 0000", req_ready); end
    reset = 1'b0; req_valid = '0; b1_valid = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_single_op();
    logic [3:0] got;
    init_stream();
    op_a[2] = 32'h4000_0000; op_b[2] = 32'h4040_0000;   // 2.0 * 3.0
    exp_q.push_back({4'b0100, 32'h40C0_0000});
    run_cycle(4'b0100, got);
    n_cmp++; if (got !== 4'b0100) begin n_fail++; $display("FAIL single_grant: got %b required 0100", got); end
    n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL single_t1: got valid=%b busy=%b required 0000/0", rsp_valid, busy); end
    run_cycle(4'b0000, got);
    n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b1) begin n_fail++; $display("FAIL single_t2: got valid=%b busy=%b required 0000/1", rsp_valid, busy); end
    run_cycle(4'b0000, got);
    n_cmp++; if (rsp_valid !== 4'b0100 || rsp_data !== 32'h40C0_0000 || busy !== 1'b1) begin
      n_fail++; $display("FAIL single_rsp: got valid=%b data=%h busy=%b required 0100/40c00000/1", rsp_valid, rsp_data, busy); end
    run_cycle(4'b0000, got);
    n_cmp++; if (rsp_valid !== 4'b0000 || rsp_data !== 32'h40C0_0000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL single_after: got valid=%b data=%h busy=%b required 0000/40c00000/0", rsp_valid, rsp_data, busy); end
  endtask

  // Pointer sits at 3 after requester 2's burst ended, so 3 wins over 0.
  task automatic test_products();
    logic [3:0] got;
    op_a[3] = 32'h3FC0_0000; op_b[3] = 32'h3FC0_0000;   // 1.5 * 1.5 = 2.25
    op_a[0] = 32'hC000_0000; op_b[0] = 32'h3F00_0000;   // -2.0 * 0.5 = -1.0
    exp_q.push_back({4'b1000, 32'h4010_0000});
    exp_q.push_back({4'b0001, 32'hBF80_0000});
    run_cycle(4'b1001, got);
    n_cmp++; if (got !== 4'b1000) begin n_fail++; $display("FAIL products_grant0: got %b required 1000", got); end
    run_cycle(4'b0001, got);
    n_cmp++; if (got !== 4'b0001) begin n_fail++; $display("FAIL products_grant1: got %b required 0001", got); end
    idle(4);
  endtask

  task automatic test_fairness();
    logic [3:0]  exp_r;
    logic [31:0] exp_d;
    for (int i = 0; i < N; i++) begin
      b1_a[i*32 +: 32] = ONE;
      b1_b[i*32 +: 32] = {1'b0, 8'(127 + i), 23'h0};
    end
    for (int c = 0; c < 8; c++) begin
      b1_valid = (c < 6) ? 4'hF : 4'h0;
      #1;
      if (c < 6) begin
        exp_r = 4'(1 << (c % 4));
        n_cmp++; if (b1_ready !== exp_r) begin n_fail++; $display("FAIL fair_grant[%0d]: got %b required %b", c, b1_ready, exp_r); end
      end
      @(posedge clk); #1;
      if (c >= 2) begin
        exp_r = 4'(1 << ((c - 2) % 4));
        exp_d = {1'b0, 8'(127 + (c - 2) % 4), 23'h0};
        n_cmp++; if ({b1_rsp_valid, b1_rsp_data} !== {exp_r, exp_d}) begin
          n_fail++; $display("FAIL fair_rsp[%0d]: got %b/%h required %b/%h", c, b1_rsp_valid, b1_rsp_data, exp_r, exp_d); end
      end
    end
    b1_valid = '0;
  endtask

  task automatic test_burst();
    logic [3:0] got, exp_r;
    int tbl[9] = '{1, 1, 1, 1, 2, 2, 2, 2, 1};
    do_reset(); init_stream();
    for (int c = 0; c < 9; c++) begin
      exp_r = 4'(1 << tbl[c]);
      exp_q.push_back({exp_r, bval(tbl[c], exp_cnt[tbl[c]])});
      exp_cnt[tbl[c]]++;
      run_cycle(4'b0110, got);
      n_cmp++; if (got !== exp_r) begin n_fail++; $display("FAIL burst_grant[%0d]: got %b required %b", c, got, exp_r); end
    end
    idle(4);
  endtask

  task automatic test_sole_burst();
    logic [3:0] got;
    do_reset(); init_stream();
    for (int c = 0; c < 12; c++) begin
      if (c < 10) exp_q.push_back({4'b1000, bval(3, c)});
      run_cycle((c < 10) ? 4'b1000 : 4'b0000, got);
      if (c < 10) begin
        n_cmp++; if (got !== 4'b1000) begin n_fail++; $display("FAIL sole_grant[%0d]: got %b required 1000", c, got); end
      end
      if (c >= 2) begin
        n_cmp++; if (rsp_valid !== 4'b1000) begin n_fail++; $display("FAIL sole_pulse[%0d]: got %b required 1000", c, rsp_valid); end
      end
    end
    idle(1);
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL sole_end: got %b required 0000", rsp_valid); end
    idle(3);
  endtask

  task automatic test_valid_drop();
    logic [3:0] got;
    logic [3:0] vt[5] = '{4'b0100, 4'b0100, 4'b0101, 4'b0001, 4'b0001};
    int         gt[5] = '{2, 2, 2, 0, 0};
    do_reset(); init_stream();
    for (int c = 0; c < 5; c++) begin
      exp_q.push_back({4'(1 << gt[c]), bval(gt[c], exp_cnt[gt[c]])});
      exp_cnt[gt[c]]++;
      run_cycle(vt[c], got);
      n_cmp++; if (got !== 4'(1 << gt[c])) begin n_fail++; $display("FAIL drop_grant[%0d]: got %b required %b", c, got, 4'(1 << gt[c])); end
    end
    idle(4);
  endtask

  task automatic test_reset_midflight();
    logic [3:0] got;
    do_reset(); init_stream();
    run_cycle(4'b0010, got);
    n_cmp++; if (got !== 4'b0010) begin n_fail++; $display("FAIL mid_grant0: got %b required 0010", got); end
    run_cycle(4'b0010, got);
    n_cmp++; if (got !== 4'b0010) begin n_fail++; $display("FAIL mid_grant1: got %b required 0010", got); end
    reset = 1'b1; req_valid = 4'b1010;
    #1;
    n_cmp++; if (req_ready !== 4'b0000) begin n_fail++; $display("FAIL mid_ready_in_reset: got %b required 0000", req_ready); end
    @(posedge clk); #1;
    reset = 1'b0;
    n_cmp++; if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_after_reset: got valid=%b busy=%b required 0000/0", rsp_valid, busy); end
    exp_q.push_back({4'b0001, bval(0, 0)});
    exp_cnt[0]++;
    run_cycle(4'b1011, got);
    n_cmp++; if (got !== 4'b0001) begin n_fail++; $display("FAIL mid_restart_grant: got %b required 0001", got); end
    n_cmp++; if (rsp_valid !== 4'b0000) begin n_fail++; $display("FAIL mid_dropped_second: got %b required 0000", rsp_valid); end
    idle(5);
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    n_cmp = 0; n_fail = 0;
    req_valid = '0; b1_valid = '0; reset = 1'b1;
    init_stream();
    test_reset();
    test_single_op();
    test_products();
    test_fairness();
    test_burst();
    test_sole_burst();
    test_valid_drop();
    test_reset_midflight();
    idle(4);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d responses outstanding, required 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/fp_mult_share_arb.md
# fp_mult_share_arb

Round-robin arbiter that shares one pipelined FP32 multiplier (`multiply_fp_clk` hard DSP) among `NUM_REQ` requesters in the LSTM datapath, such as the gate-computation lanes. It grants at most one operand pair per cycle, supports bounded bursts so a requester can stream consecutive products without interleaving, tracks the owner of every in-flight product, and routes each result back to its originator with a per-requester valid pulse.

## Interface
- `NUM_REQ`, default 4: number of requesters, range 2..8.
- `MULT_LAT`, default 1: register latency of `multiply_fp_clk`, in cycles, 1..4.
- `BURST_MAX`, default 4: maximum consecutive grants to one requester while others wait, 1..16.
- `clk` in 1: single clock. All logic is on the rising edge.
- `reset` in 1: synchronous, active-high.
- `req_valid` in `NUM_REQ`: requester i has an operand pair pending.
- `req_a` in `NUM_REQ*32`: flattened operand A. Requester i owns bits `[32i+31:32i]`.
- `req_b` in `NUM_REQ*32`: flattened operand B, same packing as `req_a`.
- `req_ready` out `NUM_REQ`: one-hot or zero grant. A transfer occurs when `req_valid[i] & req_ready[i]` is high at a rising edge.
- `rsp_valid` out `NUM_REQ`: one-hot or zero, a one-cycle pulse when requester i's product is on `rsp_data`.
- `rsp_data` out 32: FP32 product, broadcast to all requesters.
- `busy` out 1: one or more products are in flight, or an input stage is occupied.

## Operation
**Requester rules**
- `req_a` and `req_b` hold stable while `req_valid` is high and `req_ready` is low.
- Requesters always accept `rsp_valid`. There is no response backpressure.

**Grant logic**
- `req_ready` is combinational from `req_valid` and registered state: `owner`, `burst_cnt`, and the round-robin pointer `rr_ptr`.
- States:
  - ARB: no owner. Grant the first `req_valid` at or after `rr_ptr`, scanning modulo `NUM_REQ`. On a transfer, go to BURST with `owner` set to the grantee and `burst_cnt` set to 1.
  - BURST: grant `owner` while `req_valid[owner]` is high and `burst_cnt < BURST_MAX`. Each transfer increments `burst_cnt`.
    - When `req_valid[owner]` drops, or when `burst_cnt == BURST_MAX` and a different requester is valid, set `rr_ptr` to `owner+1` and re-arbitrate in the same cycle, so there is no bubble.
    - If the owner is the only valid requester at `BURST_MAX`, it is re-granted with `burst_cnt` set to 1.
- Accepted operands go into the input register stage (`a_q`, `b_q`, `v_q`, `tag_q`), which feeds the multiplier.
- A tag shift register of depth `MULT_LAT` carries valid and owner index in parallel with the multiplier.
- On the tag pipeline's output stage, `rsp_valid[tag]` is 1 and `rsp_data` equals the multiplier output.
- No arithmetic is done here. IEEE handling (NaN, inf, denormals) is whatever the DSP produces.

**Reset**
- `reset` high at an edge clears `v_q` and all tag-pipeline valids, sets `rr_ptr` to 0, and returns the FSM to ARB.
- Products already in flight are dropped silently and never pulse `rsp_valid`, including mid-burst.
- While `reset` is high, `req_ready` is forced to 0.

## Timing
- Reset values:
  - `req_ready` = 0, `rsp_valid` = 0.
  - `rsp_data` = 0. It is registered and holds its last value when `rsp_valid` is low.
  - `busy` = 0.
- Latency: a transfer at edge k gives `rsp_valid` high for exactly the cycle after edge k+1+`MULT_LAT`, i.e. 2 cycles at default.
- Throughput: one transfer per cycle, sustained across requester switches.
- Ordering: responses come back in acceptance order, so per-requester order is preserved.
- `busy` = `v_q` OR any tag valid, registered.

## Structure
- Package `fp_arb_pkg` holds:
  - `FP32_W` = 32.
  - A `state_t` enum {ARB, BURST}.
  - The function `rr_pick(valid, ptr)`, which returns the index and a found flag.
- One sub-module, `fp_mult_tag_pipe`, is the `MULT_LAT`-deep valid/tag shift register with synchronous clear.
- `multiply_fp_clk` is instantiated directly with ports `a`, `b`, `clk`, `out`.

## Test plan
- Single op:
  - Stimulus: reset, then requester 2 sends A=0x40000000 (2.0), B=0x40400000 (3.0).
  - Required response: `rsp_valid`=4'b0100 exactly 2 cycles after the transfer, `rsp_data`=0x40C00000, and `busy` drops the cycle after.
- Fairness:
  - Stimulus: `BURST_MAX`=1, all four requesters valid continuously.
  - Required response: grant order 0,1,2,3,0,1, with no idle cycles.
- Burst:
  - Stimulus: `BURST_MAX`=4, requesters 1 and 2 continuously valid.
  - Required response: grants 1,1,1,1,2,2,2,2,1, and responses arrive in the same order with the matching tags.
- Sole requester at the burst limit:
  - Stimulus: only requester 3 valid for 10 cycles.
  - Required response: 10 back-to-back transfers, and 10 `rsp_valid[3]` pulses with no gaps.
- Reset mid-flight:
  - Stimulus: 2 transfers accepted, then `reset` pulses for 1 cycle on the next edge.
  - Required response: no `rsp_valid` pulse for either transfer, `req_ready`=0 during reset, and the next arbitration starts from requester 0.
- Valid drop:
  - Stimulus: the owner deasserts `req_valid` mid-burst while requester 0 waits.
  - Required response: requester 0 is granted in that same cycle.
